// File: rtl/lfsr_normal_ctrl.sv
// lfsr_normal_ctrl
// Sequencer for a free-running 32-bit Fibonacci LFSR. It seeds the LFSR,
// discards a warm-up run, then sums NSAMP truncated uniform words into one
// approximately Gaussian signed sample. Each sample is offered on a
// valid/ready handshake. A seed_load in any state restarts the sequence.
module lfsr_normal_ctrl #(
  parameter int NSAMP  = 16,
  parameter int LOG2N  = 4,
  parameter int SW     = 8,
  parameter int WARMUP = 32,
  parameter int OW     = SW + LOG2N + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   seed_in,
  input  logic          seed_load,
  input  logic [31:0]   lfsr_num,
  output logic [31:0]   lfsr_seed,
  output logic          lfsr_write,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  // Accumulator width: NSAMP words of SW bits can never overflow it.
  localparam int AW  = SW + LOG2N;
  localparam int WCW = $clog2(WARMUP) + 1;
  localparam int CW  = (WCW > LOG2N + 1) ? WCW : LOG2N + 1;

  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
  localparam logic [CW-1:0] ACC_LAST  = CW'(NSAMP - 1);
  // Mean of the sum, subtracted so that the output is centred on zero.
  localparam logic [OW-1:0] OFFSET    = OW'(longint'(NSAMP) << (SW - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WARM,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_acc,   w_acc_nxt;
  logic [CW-1:0]   r_cnt,   w_cnt_nxt;
  logic [31:0]     r_seed,  w_seed_nxt;
  logic            r_write, w_write_nxt;
  logic [OW-1:0]   r_data,  w_data_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_busy,  w_busy_nxt;

  logic [AW-1:0]   w_sample;
  logic [AW-1:0]   w_sum;
  logic [31:0]     w_seed_val;
  logic            w_unused_lfsr;

  // Only the top SW bits of each LFSR word are sampled.
  assign w_sample      = AW'(lfsr_num[31 -: SW]);
  assign w_sum         = r_acc + w_sample;
  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  assign w_seed_val    = (seed_in == '0) ? 32'h0000_0001 : seed_in;
  assign w_unused_lfsr = ^lfsr_num;

  // State and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_seed  <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_seed  <= w_seed_nxt;
      r_write <= w_write_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic. A seed_load takes priority over
  // everything, including a handshake that completes in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_seed_nxt  = r_seed;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;

    if (seed_load) begin
      w_seed_nxt  = w_seed_val;
      w_state_nxt = S_SEED;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_SEED: begin
          w_state_nxt = S_WARM;
          w_cnt_nxt   = '0;
        end
        S_WARM: begin
          if (r_cnt == WARM_LAST) begin
            w_state_nxt = S_ACCUM;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          w_acc_nxt = w_sum;
          if (r_cnt == ACC_LAST) begin
            w_data_nxt  = OW'(w_sum) - OFFSET;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_valid && out_ready) begin
            w_valid_nxt = 1'b0;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_ACCUM;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Write strobe and busy are registered copies of the state being entered.
    w_write_nxt = (w_state_nxt == S_SEED);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  assign lfsr_seed  = r_seed;
  assign lfsr_write = r_write;
  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_lfsr_normal_ctrl.sv
// Testbench for lfsr_normal_ctrl: directed stimulus, an event-timed
// behavioural model checked every cycle, plus literal spot checks.
module tb_lfsr_normal_ctrl;

  localparam int NSAMP  = 16;
  localparam int LOG2N  = 4;
  localparam int SW     = 8;
  localparam int WARMUP = 32;
  localparam int OW     = SW + LOG2N + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   seed_in;
  logic          seed_load;
  logic [31:0]   lfsr_num;
  logic [31:0]   lfsr_seed;
  logic          lfsr_write;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  always #5 clk = ~clk;

  lfsr_normal_ctrl #(
    .NSAMP (NSAMP),
    .LOG2N (LOG2N),
    .SW    (SW),
    .WARMUP(WARMUP),
    .OW    (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_in   (seed_in),
    .seed_load (seed_load),
    .lfsr_num  (lfsr_num),
    .lfsr_seed (lfsr_seed),
    .lfsr_write(lfsr_write),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // LFSR word source: constant, or alternating 0x80/0x7F top bytes.
  int          mode      = 0;
  logic [31:0] num_const = '0;
  logic        alt       = 1'b0;
  always @(negedge clk) begin
    alt = ~alt;
    lfsr_num = (mode == 1) ? (alt ? 32'h8000_0000 : 32'h7F00_0000) : num_const;
  end

  // Model: results are described by the edge at which they complete.
  // A load at edge e completes at e+1+WARMUP+NSAMP, a handshake at edge h
  // starts a new result completing at h+NSAMP; the value is the sum of the
  // top bytes seen on the last NSAMP edges, minus the mean.
  int            e = 0;
  int            hist [64];
  bit            started = 0;
  logic [31:0]   m_seed  = '0;
  logic          m_write = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_busy  = 1'b0;
  logic [OW-1:0] m_data  = '0;
  int            m_done  = -1;

  always @(posedge clk) begin : model
    int s;
    started = 1;
    hist[e & 63] = int'(lfsr_num[31:24]);
    if (!rst_n) begin
      m_seed = '0; m_write = 0; m_valid = 0; m_busy = 0; m_data = '0; m_done = -1;
    end else if (seed_load) begin
      m_seed  = (seed_in == 0) ? 32'h1 : seed_in;
      m_write = 1;
      m_valid = 0;
      m_busy  = 1;
      m_done  = e + 1 + WARMUP + NSAMP;
    end else begin
      m_write = 0;
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          m_done  = e + NSAMP;
        end
      end else if (m_done == e) begin
        s = 0;
        for (int k = 0; k < NSAMP; k++) s += hist[(e - k) & 63];
        m_valid = 1;
        m_data  = OW'(s - NSAMP * (1 << (SW - 1)));
      end
    end
    e++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("model_out_data",   64'(out_data),   64'(m_data));
      chk("model_out_valid",  64'(out_valid),  64'(m_valid));
      chk("model_lfsr_seed",  64'(lfsr_seed),  64'(m_seed));
      chk("model_lfsr_write", 64'(lfsr_write), 64'(m_write));
      chk("model_busy",       64'(busy),       64'(m_busy));
    end
  end

  // Counts edges, starting with the next one, until out_valid is seen.
  task automatic wait_valid(input string name, input int exp_n);
    int n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!out_valid && n < 300);
    chk(name, 64'(n), 64'(exp_n));
  endtask

  // Loads a seed and counts edges from the load edge until out_valid.
  task automatic load_timed(input string name, input logic [31:0] seed, input int exp_n);
    int n;
    seed_in   = seed;
    seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    n = 1;
    chk({name, "_write"}, 64'(lfsr_write), 64'd1);
    chk({name, "_valid_dropped"}, 64'(out_valid), 64'd0);
    while (!out_valid && n < 300) begin
      @(posedge clk); n++; #1;
    end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed_in = '0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seed_in   = $urandom;
      seed_load = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      num_const = $urandom;
    end
    @(negedge clk);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_lfsr_write", 64'(lfsr_write), 64'd0);
    chk("rst_lfsr_seed",  64'(lfsr_seed),  64'd0);
    chk("rst_out_data",   64'(out_data),   64'd0);

    rst_n = 1'b1; seed_load = 1'b0; out_ready = 1'b1; num_const = 32'hFF00_0000;
    repeat (5) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Zero seed is replaced by 1; the write strobe lasts one cycle.
    seed_in = '0; seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    chk("zero_seed", 64'(lfsr_seed), 64'h1);
    chk("seed_write_hi", 64'(lfsr_write), 64'd1);
    @(posedge clk); #1;
    chk("seed_write_lo", 64'(lfsr_write), 64'd0);
    repeat (10) @(posedge clk);
    #1;

    // Reload during warm-up, then latency and throughput.
    load_timed("latency_ace1", 32'h0000_ACE1, 50);
    chk("seed_ace1", 64'(lfsr_seed), 64'h0000_ACE1);
    chk("max_sum", 64'(out_data), 64'h07F0);
    wait_valid("throughput", 17);
    chk("max_sum2", 64'(out_data), 64'h07F0);

    num_const = '0;
    wait_valid("throughput_zero", 17);
    chk("min_sum", 64'(out_data), 64'h1800);

    mode = 1;
    wait_valid("throughput_alt", 17);
    chk("alt_sum", 64'(out_data), 64'h1FF8);

    mode = 0; num_const = 32'hFF00_0000;
    wait_valid("throughput_max", 17);
    chk("max_sum3", 64'(out_data), 64'h07F0);

    // Back-pressure: result held for 100 cycles, then one transfer.
    out_ready = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      chk("hold_data",  64'(out_data),  64'h07F0);
      chk("hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    wait_valid("release", 17);

    // Reload on the 8th accumulation cycle.
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    load_timed("reload_accum", 32'h0000_1234, 50);

    // Reload in the same cycle as a completing handshake.
    load_timed("reload_handshake", 32'h0000_5555, 50);

    // Reload during the seed cycle itself.
    seed_in = 32'hDEAD_BEEF; seed_load = 1'b1;
    @(posedge clk); #1;
    chk("double_first_write", 64'(lfsr_write), 64'd1);
    load_timed("double_load", 32'h0BAD_F00D, 50);
    chk("double_seed", 64'(lfsr_seed), 64'h0BAD_F00D);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
